trivium_stream_xor: RTL

Byte-wide stream-cipher stage directly downstream of the `trivium` keystream core inside the tt_um top. It drives the core's `enable`, discards the warm-up bits and packs keystream bits into bytes LSB-first. It then XORs each byte with one plaintext/ciphertext byte accepted over a valid/ready handshake, and presents the result over a second valid/ready handshake.

---
 rtl/trivium_pkg.sv | 14 +
 rtl/trivium_ks_packer.sv | 48 ++++
 rtl/trivium_stream_xor.sv | 105 ++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium keystream path: state encoding
// for the stream XOR stage and the default warm-up length.
package trivium_pkg;

  localparam int TRIVIUM_WARMUP = 1152;
  localparam int KS_BYTE_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } xor_state_t;

endpackage

// File: rtl/trivium_ks_packer.sv
// Packs keystream bits LSB-first into a byte and holds it until consumed;
// the core is only enabled while the byte register still has room.
module trivium_ks_packer
  import trivium_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_run,
  input  logic                 i_ks_bit,
  input  logic                 i_consume,
  output logic                 o_ks_en,
  output logic [KS_BYTE_W-1:0] o_ks_byte,
  output logic                 o_ks_full
);

  localparam int BCNT_W = $clog2(KS_BYTE_W);

  logic [BCNT_W-1:0]    r_bcnt;
  logic [KS_BYTE_W-1:0] r_ks_byte;
  logic                 r_ks_full;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt    <= '0;
      r_ks_byte <= '0;
      r_ks_full <= 1'b0;
    end else if (i_clr) begin
      r_bcnt    <= '0;
      r_ks_full <= 1'b0;
    end else if (i_run && !r_ks_full) begin
      r_ks_byte[r_bcnt] <= i_ks_bit;
      r_bcnt            <= r_bcnt + 1'b1;
      if (r_bcnt == BCNT_W'(KS_BYTE_W - 1)) begin
        r_ks_full <= 1'b1;
      end
    end else if (i_consume) begin
      r_ks_full <= 1'b0;
    end
  end

  assign o_ks_en   = i_run && !r_ks_full;
  assign o_ks_byte = r_ks_byte;
  assign o_ks_full = r_ks_full;

endmodule

// File: rtl/trivium_stream_xor.sv
// Byte-wide stream-cipher stage: discards warm-up keystream, then XORs each
// accepted input byte with the next packed keystream byte.
module trivium_stream_xor
  import trivium_pkg::*;
#(
  parameter int WARMUP = TRIVIUM_WARMUP,
  parameter int CW     = $clog2(WARMUP + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ks_en,
  input  logic       ks_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       warm_done
);

  // Keeps the counter legal when WARMUP is 0 and the WARMUP state is unused.
  localparam int             WCW       = (CW < 1) ? 1 : CW;
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(WARMUP - 1);

  xor_state_t     r_state;
  logic [WCW-1:0] r_wcnt;
  logic           r_warm_done;
  logic           r_out_valid;
  logic [7:0]     r_out_data;

  logic           w_run;
  logic           w_pk_en;
  logic           w_ks_full;
  logic [7:0]     w_ks_byte;
  logic           w_in_hs;
  logic           w_out_hs;

  assign w_run    = (r_state == RUN);
  assign in_ready = w_run && w_ks_full && (!r_out_valid || out_ready);
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;
  assign ks_en    = (r_state == trivium_pkg::WARMUP) || w_pk_en;

  trivium_ks_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (start),
    .i_run     (w_run),
    .i_ks_bit  (ks_bit),
    .i_consume (w_in_hs),
    .o_ks_en   (w_pk_en),
    .o_ks_byte (w_ks_byte),
    .o_ks_full (w_ks_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_warm_done <= 1'b0;
    end else if (start) begin
      r_wcnt <= '0;
      if (WARMUP == 0) begin
        r_state     <= RUN;
        r_warm_done <= 1'b1;
      end else begin
        r_state     <= trivium_pkg::WARMUP;
        r_warm_done <= 1'b0;
      end
    end else begin
      case (r_state)
        trivium_pkg::WARMUP: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == WCNT_LAST) begin
            r_state     <= RUN;
            r_warm_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // start outranks both handshakes, so a pending byte is dropped on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else if (start) begin
      r_out_valid <= 1'b0;
    end else if (w_in_hs) begin
      r_out_data  <= in_data ^ w_ks_byte;
      r_out_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign warm_done = r_warm_done;

endmodule
